// File: rtl/alu_serial_seq_if.sv
// Request/response bundle between a client and the alu_serial_seq bit-serial sequencer.
// ALU_SERIAL_FLAGS_EN adds the zero/carry/ovf result flags.
interface alu_serial_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
`ifdef ALU_SERIAL_FLAGS_EN
    logic             zero;
    logic             carry;
    logic             ovf;
`endif

    modport master (
        output start, op, a, b,
        input  busy, done, result
`ifdef ALU_SERIAL_FLAGS_EN
        , input zero, carry, ovf
`endif
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result
`ifdef ALU_SERIAL_FLAGS_EN
        , output zero, carry, ovf
`endif
    );
endinterface

// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer driving an external 1-bit ALU slice over WIDTH cycles.
// Optional result flags (zero/carry/ovf) are built when ALU_SERIAL_FLAGS_EN is defined.
module alu_serial_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_serial_seq_if.slave bus,
    output logic           s_aluop0,
    output logic           s_aluop1,
    output logic           s_aluop2,
    output logic           s_ai,
    output logic           s_bi,
    output logic           s_lessi,
    output logic           s_cin,
    input  logic           s_outp,
    input  logic           s_cout
);
    localparam int unsigned     IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d, result_q, result_d;
    logic [WIDTH-1:0] sh_next, res_fin;
    logic [2:0]       op_q, op_d, s_aluop_q, s_aluop_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             s_ai_q, s_ai_d, s_bi_q, s_bi_d, s_cin_q, s_cin_d;
    logic             last_bit, is_arith, slt_bit;

    // SLT runs the slice as a subtract; illegal codes park it on AND.
    function automatic logic [2:0] slice_op(input logic [2:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB: slice_op = op;
            OP_SLT:                        slice_op = OP_SUB;
            default:                       slice_op = 3'b000;
        endcase
    endfunction

    // Final result as it will be registered on the RUN->DONE edge.
    always_comb begin
        last_bit = (state_q == RUN) && (idx_q == IDX_LAST);
        is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
        sh_next  = {s_outp, sh_q[WIDTH-1:1]};
        slt_bit  = s_outp ^ s_cin_q ^ s_cout;
        case (op_q)
            OP_AND, OP_OR, OP_ADD, OP_SUB: res_fin = sh_next;
            OP_SLT:  res_fin = {{(WIDTH-1){1'b0}}, slt_bit};
            default: res_fin = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        sh_d      = sh_q;
        idx_d     = idx_q;
        result_d  = result_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        s_aluop_d = s_aluop_q;
        s_ai_d    = s_ai_q;
        s_bi_d    = s_bi_q;
        s_cin_d   = s_cin_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d       = bus.a;
                    b_d       = bus.b;
                    op_d      = bus.op;
                    idx_d     = '0;
                    busy_d    = 1'b1;
                    s_aluop_d = slice_op(bus.op);
                    s_ai_d    = bus.a[0];
                    s_bi_d    = bus.b[0];
                    s_cin_d   = bus.op[2];
                    state_d   = RUN;
                end
            end
            RUN: begin
                // Operands shift right so bit 1 always feeds the next slice cycle.
                sh_d    = sh_next;
                idx_d   = idx_q + 1'b1;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                s_ai_d  = a_q[1];
                s_bi_d  = b_q[1];
                s_cin_d = s_cout;
                if (last_bit) begin
                    result_d  = res_fin;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    s_aluop_d = 3'b000;
                    s_ai_d    = 1'b0;
                    s_bi_d    = 1'b0;
                    s_cin_d   = 1'b0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            sh_q      <= '0;
            idx_q     <= '0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            s_aluop_q <= '0;
            s_ai_q    <= 1'b0;
            s_bi_q    <= 1'b0;
            s_cin_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            sh_q      <= sh_d;
            idx_q     <= idx_d;
            result_q  <= result_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            s_aluop_q <= s_aluop_d;
            s_ai_q    <= s_ai_d;
            s_bi_q    <= s_bi_d;
            s_cin_q   <= s_cin_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign s_aluop0   = s_aluop_q[0];
    assign s_aluop1   = s_aluop_q[1];
    assign s_aluop2   = s_aluop_q[2];
    assign s_ai       = s_ai_q;
    assign s_bi       = s_bi_q;
    assign s_cin      = s_cin_q;
    assign s_lessi    = 1'b0;

`ifdef ALU_SERIAL_FLAGS_EN
    logic zero_flag_q, zero_flag_d, carry_flag_q, carry_flag_d, ovf_flag_q, ovf_flag_d;

    // Flags share the result's update edge.
    always_comb begin
        zero_flag_d  = zero_flag_q;
        carry_flag_d = carry_flag_q;
        ovf_flag_d   = ovf_flag_q;
        if (last_bit) begin
            zero_flag_d  = (res_fin == '0);
            carry_flag_d = is_arith & s_cout;
            ovf_flag_d   = (is_arith || (op_q == OP_SLT)) & (s_cin_q ^ s_cout);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_flag_q  <= 1'b0;
            carry_flag_q <= 1'b0;
            ovf_flag_q   <= 1'b0;
        end else begin
            zero_flag_q  <= zero_flag_d;
            carry_flag_q <= carry_flag_d;
            ovf_flag_q   <= ovf_flag_d;
        end
    end

    assign bus.zero  = zero_flag_q;
    assign bus.carry = carry_flag_q;
    assign bus.ovf   = ovf_flag_q;
`endif
endmodule

// File: doc/alu_serial_seq.md
Name: alu_serial_seq

Overview:
Bit-serial sequencer that drives one external 1-bit ALU slice over WIDTH cycles to perform a full-width operation. It sits directly upstream of the slice. Each cycle it feeds the slice one operand bit pair, the op select lines, carry-in and less-in. It registers the slice's outp/cout, assembles the WIDTH-bit result and handles SLT sign resolution. Used where area matters more than latency.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
op  in  3  {aluop2,aluop1,aluop0}: 000 AND, 010 OR, 001 ADD, 101 SUB, 111 SLT; others illegal
a  in  WIDTH  operand A, latched on accept
b  in  WIDTH  operand B, latched on accept
busy  out  1  high in RUN
done  out  1  one-cycle pulse when result is valid
result  out  WIDTH  final result, held until next accept
s_aluop0  out  1  slice op select bit 0
s_aluop1  out  1  slice op select bit 1
s_aluop2  out  1  slice b-invert
s_ai  out  1  slice operand A bit
s_bi  out  1  slice operand B bit
s_lessi  out  1  slice less input
s_cin  out  1  slice carry-in
s_outp  in  1  slice result bit (combinational from the s_* outputs)
s_cout  in  1  slice carry-out

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - state=IDLE; busy=0, done=0, result=0, all s_* outputs=0.
  - Internal a_q, b_q, op_q, idx, carry_q are cleared to 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge latches a, b, op; idx<=0; next state RUN.
  - In IDLE the s_* outputs are all 0.
- RUN (busy=1):
  - Drive s_ai=a_q[idx], s_bi=b_q[idx].
  - s_cin = op_q[2] when idx==0, else carry_q.
  - s_lessi=0 always.
  - s_aluop = op_q, except SLT drives 101 (subtract) and illegal ops drive 000.
  - At each edge:
    - shift s_outp into the result shift register MSB (shift right);
    - carry_q<=s_cout; idx<=idx+1.
  - When idx==WIDTH-1, also capture msb_sum=s_outp, msb_cin=s_cin, msb_cout=s_cout, then go to DONE.
- DONE (one cycle):
  - done=1, busy=0.
  - result takes its final value at the RUN->DONE edge:
    - AND/OR/ADD/SUB: assembled shift register, arithmetic mod 2^WIDTH.
    - SLT: {WIDTH-1 zeros, msb_sum ^ (msb_cin ^ msb_cout)} (signed compare, overflow-corrected).
    - Illegal op: all zeros.
  - Next state IDLE unconditionally.
- Latency: accept at edge k; done high in the cycle after edge k+WIDTH; exactly WIDTH RUN cycles.
- start during RUN or DONE is ignored, not queued. Back-to-back throughput is one op per WIDTH+2 cycles.
- result is not modified during RUN; a separate shift register is used. result holds the previous value until the RUN->DONE edge.
- Reset asserted mid-RUN aborts immediately to reset values; no done pulse.

Optional Feature:
- Macro ALU_SERIAL_FLAGS_EN.
- When defined, adds outputs zero (1), carry (1) and ovf (1), valid and updated with result at the RUN->DONE edge:
  - zero = (result==0);
  - carry = msb_cout for ADD/SUB, else 0;
  - ovf = msb_cin^msb_cout for ADD/SUB/SLT, else 0.
  - All three reset to 0.
- When undefined, these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- WIDTH=8, ADD a=8'h3C b=8'h05, start pulse -> busy for 8 cycles, done one cycle later, result=8'h41.
- SUB a=8'h05 b=8'h07 -> result=8'hFE. SLT a=8'hFD b=8'h02 -> result=8'h01. SLT a=8'h02 b=8'hFD -> result=8'h00.
- SLT a=8'h80 b=8'h01 (subtract overflows) -> result=8'h01. AND 8'hF0/8'h3C -> 8'h30. OR -> 8'hFC. Illegal op 3'b011 -> 8'h00 with normal done timing.
- start held high through RUN with different operands -> second op only begins after IDLE; first result unaffected.
- rst_n low at RUN cycle 4 -> busy, done, result and s_* all 0 asynchronously; no done pulse. Next start after release completes normally.
- With ALU_SERIAL_FLAGS_EN, ADD 8'hFF+8'h01 -> result=8'h00, zero=1, carry=1, ovf=0. ADD 8'h7F+8'h01 -> result=8'h80, ovf=1.
